// File: rtl/instr_seq_ctrl_if.sv
// Handshake and control bundle between instr_seq_ctrl and the core top level.
// The core side uses the master modport, the sequencer the slave modport.
interface instr_seq_ctrl_if;
    logic [31:0] instr;
    logic [11:0] control_signals;
    logic        run;
    logic        step;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        ir_we;
    logic        pc_we;
    logic        rf_we;
    logic [2:0]  state;
    logic        halted;
    logic        timeout_err;
    logic [31:0] instret;

    modport master (
        output instr, control_signals, run, step, imem_ready, dmem_ready,
        input  imem_req, dmem_req, ir_we, pc_we, rf_we, state, halted, timeout_err, instret
    );

    modport slave (
        input  instr, control_signals, run, step, imem_ready, dmem_ready,
        output imem_req, dmem_req, ir_we, pc_we, rf_we, state, halted, timeout_err, instret
    );
endinterface

// File: rtl/instr_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer with run/step/halt control.
// Define SEQ_TIMEOUT_EN to add a memory-handshake wait timeout that halts the core.
//
// state   | meaning
// IDLE    | waiting for run or a step pulse
// FETCH   | instruction memory request outstanding
// DECODE  | decoder settles on the latched word; EBREAK halts here
// EXECUTE | one ALU cycle, branches to MEM for loads/stores
// MEM     | data memory request outstanding
// WB      | register write, PC update, retire
// HALT    | stopped until reset
module instr_seq_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              reset_rf,
    instr_seq_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXECUTE = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6
    } state_t;

    localparam logic [31:0] EBREAK    = 32'h0010_0073;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;

    state_t      st;
    logic [31:0] ir_q;
    logic [31:0] instret_q;
    logic        wait_expire;
    logic        unused_cs;

    assign unused_cs = ^bus.control_signals[10:0];

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic          waiting;
    logic          timeout_q;

    assign waiting     = ((st == S_FETCH) && !bus.imem_ready) ||
                         ((st == S_MEM)   && !bus.dmem_ready);
    // Fires on the waiting cycle that brings the count up to TIMEOUT_CYCLES.
    assign wait_expire = waiting && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset_rf) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (waiting) wait_cnt <= wait_cnt + CW'(1);
            else         wait_cnt <= '0;
            if (wait_expire) timeout_q <= 1'b1;
        end
    end

    assign bus.timeout_err = timeout_q;
`else
    assign wait_expire     = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset_rf) begin
            st        <= S_IDLE;
            ir_q      <= '0;
            instret_q <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (bus.run || bus.step) st <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        ir_q <= bus.instr;
                        st   <= S_DECODE;
                    end else if (wait_expire) begin
                        st <= S_HALT;
                    end
                end
                S_DECODE: begin
                    st <= (ir_q == EBREAK) ? S_HALT : S_EXECUTE;
                end
                S_EXECUTE: begin
                    st <= (ir_q[6:0] == OP_LOAD || ir_q[6:0] == OP_STORE) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (bus.dmem_ready)   st <= S_WB;
                    else if (wait_expire) st <= S_HALT;
                end
                S_WB: begin
                    instret_q <= instret_q + 32'd1;
                    st        <= bus.run ? S_FETCH : S_IDLE;
                end
                S_HALT: st <= S_HALT;
                default: st <= S_IDLE;
            endcase
        end
    end

    // Requests come straight from the state register; only ir_we and rf_we look at inputs.
    assign bus.imem_req = (st == S_FETCH);
    assign bus.dmem_req = (st == S_MEM);
    assign bus.ir_we    = (st == S_FETCH) && bus.imem_ready;
    assign bus.pc_we    = (st == S_WB);
    assign bus.rf_we    = (st == S_WB) && bus.control_signals[11];
    assign bus.halted   = (st == S_HALT);
    assign bus.state    = st;
    assign bus.instret  = instret_q;
endmodule
